// File: rtl/hc_sched_pkg.sv
// Shared definitions for the h*C step scheduler: state encoding and default sizing.
package hc_sched_pkg;

    localparam int SEQ_W_DEF   = 10;
    localparam int TIMEOUT_DEF = 512;
    localparam int TO_W_DEF    = 10;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_FETCH      = 3'd1;
    localparam logic [2:0] ST_ISSUE      = 3'd2;
    localparam logic [2:0] ST_WAIT       = 3'd3;
    localparam logic [2:0] ST_ABORT_WAIT = 3'd4;
    localparam logic [2:0] ST_DRAIN      = 3'd5;
    localparam logic [2:0] ST_FINISH     = 3'd6;

endpackage

// File: rtl/hc_step_watchdog.sv
// Cycle counter bounding how long the scheduler waits for core_done.
// expired fires in the cycle where the counter is about to reach TIMEOUT-1.
module hc_step_watchdog #(
    parameter int TIMEOUT = 512,
    parameter int TO_W    = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] count_q;
    logic [TO_W-1:0] count_d;
    logic [TO_W-1:0] count_inc;

    always_comb begin
        count_inc = count_q + TO_W'(1);
        count_d   = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_inc;
        end
    end

    // Expiry lines up so that an error becomes visible TIMEOUT cycles after core_start.
    assign expired = enable && !clear && (count_inc == LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/hc_step_scheduler.sv
// Token sequencer for the pipelined h*C datapath: fetch a descriptor, start the core,
// wait for completion under a watchdog, hand the result downstream, repeat.
module hc_step_scheduler
    import hc_sched_pkg::*;
#(
    parameter int SEQ_W   = SEQ_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int TO_W    = TO_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SEQ_W-1:0] cfg_seq_len,
    input  logic             cfg_go,
    input  logic             abort,
    input  logic             tok_valid,
    output logic             tok_ready,
    output logic             core_start,
    input  logic             core_done,
    output logic             h_sel,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_last,
    output logic [SEQ_W-1:0] tok_idx,
    output logic             busy,
    output logic             run_done,
    output logic             err_timeout,
    output logic             err_spurious
);

    logic [2:0]       state_q, state_d;
    logic [SEQ_W-1:0] seq_len_q, seq_len_d;
    logic [SEQ_W-1:0] tok_idx_q, tok_idx_d;
    logic             h_sel_q, h_sel_d;
    logic             err_timeout_q, err_timeout_d;
    logic             err_spurious_q, err_spurious_d;

    logic wd_clear;
    logic wd_enable;
    logic wd_expired;
    logic is_last;

    assign is_last   = (tok_idx_q == seq_len_q - SEQ_W'(1));
    assign wd_clear  = (state_q == ST_ISSUE);
    assign wd_enable = (state_q == ST_WAIT) || (state_q == ST_ABORT_WAIT);

    hc_step_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            seq_len_q      <= '0;
            tok_idx_q      <= '0;
            h_sel_q        <= 1'b0;
            err_timeout_q  <= 1'b0;
            err_spurious_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            seq_len_q      <= seq_len_d;
            tok_idx_q      <= tok_idx_d;
            h_sel_q        <= h_sel_d;
            err_timeout_q  <= err_timeout_d;
            err_spurious_q <= err_spurious_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        seq_len_d      = seq_len_q;
        tok_idx_d      = tok_idx_q;
        err_timeout_d  = err_timeout_q;
        err_spurious_d = err_spurious_q;

        case (state_q)
            ST_IDLE: begin
                if (cfg_go) begin
                    seq_len_d      = cfg_seq_len;
                    tok_idx_d      = '0;
                    err_timeout_d  = 1'b0;
                    err_spurious_d = 1'b0;
                    state_d        = (cfg_seq_len == '0) ? ST_FINISH : ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (abort) begin
                    state_d = ST_FINISH;
                end else if (tok_valid) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Completion beats both expiry and abort in the same cycle.
                if (core_done) begin
                    state_d = ST_DRAIN;
                end else if (wd_expired) begin
                    err_timeout_d = 1'b1;
                    state_d       = ST_FINISH;
                end else if (abort) begin
                    state_d = ST_ABORT_WAIT;
                end
            end
            ST_ABORT_WAIT: begin
                if (core_done) begin
                    state_d = ST_FINISH;
                end else if (wd_expired) begin
                    err_timeout_d = 1'b1;
                    state_d       = ST_FINISH;
                end
            end
            ST_DRAIN: begin
                if (res_ready) begin
                    if (is_last || abort) begin
                        state_d = ST_FINISH;
                    end else begin
                        tok_idx_d = tok_idx_q + SEQ_W'(1);
                        state_d   = ST_FETCH;
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A completion pulse nobody is waiting for is latched as an error.
        if (core_done && (state_q != ST_WAIT) && (state_q != ST_ABORT_WAIT)) begin
            err_spurious_d = 1'b1;
        end

        h_sel_d = (tok_idx_d != '0);
    end

    always_comb begin
        tok_ready    = (state_q == ST_FETCH) && !abort;
        core_start   = (state_q == ST_ISSUE);
        res_valid    = (state_q == ST_DRAIN);
        res_last     = (state_q == ST_DRAIN) && is_last;
        busy         = (state_q != ST_IDLE);
        run_done     = (state_q == ST_FINISH);
        h_sel        = h_sel_q;
        tok_idx      = tok_idx_q;
        err_timeout  = err_timeout_q;
        err_spurious = err_spurious_q;
    end

endmodule

// File: tb/tb_hc_step_scheduler.sv
// Scoreboard bench for hc_step_scheduler: runs are planned from the token rules,
// expected result beats are queued, and a negedge monitor checks everything the DUT emits.
module tb_hc_step_scheduler;

    localparam int SEQ_W   = 10;
    localparam int TIMEOUT = 512;
    localparam int TO_W    = 10;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [SEQ_W-1:0] cfg_seq_len;
    logic             cfg_go;
    logic             abort;
    logic             tok_valid;
    logic             tok_ready;
    logic             core_start;
    logic             core_done;
    logic             h_sel;
    logic             res_valid;
    logic             res_ready;
    logic             res_last;
    logic [SEQ_W-1:0] tok_idx;
    logic             busy;
    logic             run_done;
    logic             err_timeout;
    logic             err_spurious;

    hc_step_scheduler #(
        .SEQ_W   (SEQ_W),
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_seq_len  (cfg_seq_len),
        .cfg_go       (cfg_go),
        .abort        (abort),
        .tok_valid    (tok_valid),
        .tok_ready    (tok_ready),
        .core_start   (core_start),
        .core_done    (core_done),
        .h_sel        (h_sel),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_last     (res_last),
        .tok_idx      (tok_idx),
        .busy         (busy),
        .run_done     (run_done),
        .err_timeout  (err_timeout),
        .err_spurious (err_spurious)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [SEQ_W-1:0] idx;
        logic             hsel;
        logic             last;
    } res_t;

    res_t exp_q[$];
    res_t mon_r;

    int compared   = 0;
    int mismatched = 0;

    int   core_lat   = 40;
    int   core_cnt   = 0;
    logic spur_req   = 1'b0;
    int   valid_pct  = 100;
    int   ready_pct  = 100;

    int   exp_starts       = 0;
    int   start_in_run     = 0;
    int   tok_ready_in_run = 0;
    logic mon_en           = 1'b0;

    logic             prev_accept = 1'b0;
    logic             prev_done   = 1'b0;
    logic             prev_rv     = 1'b0;
    logic             prev_rr     = 1'b0;
    logic             prev_last   = 1'b0;
    logic             prev_abort  = 1'b0;
    logic [SEQ_W-1:0] prev_idx    = '0;

    function automatic void check(string name, longint act, longint want);
        compared++;
        if (act != want) begin
            mismatched++;
            $display("FAIL %s: got %0d, want %0d", name, act, want);
        end
    endfunction

    function automatic void fail_now(string name, string what);
        compared++;
        mismatched++;
        $display("FAIL %s: %s", name, what);
    endfunction

    // Datapath stand-in: completes core_lat cycles after each start (0 = never).
    initial begin
        core_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            core_done = 1'b0;
            if (spur_req) begin
                core_done = 1'b1;
                spur_req  = 1'b0;
            end
            if (core_cnt > 0) begin
                core_cnt--;
                if (core_cnt == 0) core_done = 1'b1;
            end
            if (core_start && core_lat > 0) core_cnt = core_lat;
        end
    end

    // Random token availability and downstream backpressure.
    initial begin
        tok_valid = 1'b0;
        res_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            tok_valid = (int'($urandom_range(0, 99)) < valid_pct);
            res_ready = (int'($urandom_range(0, 99)) < ready_pct);
        end
    end

    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (tok_ready) tok_ready_in_run++;
            if (core_start) begin
                check("start_after_accept", prev_accept, 1);
                check("h_sel_at_start", h_sel, (start_in_run != 0));
                start_in_run++;
            end
            if (res_valid && !prev_rv) check("res_after_done", prev_done, 1);
            if (prev_rv && !prev_rr) begin
                check("res_valid_held", res_valid, 1);
                check("tok_idx_held", tok_idx, prev_idx);
            end
            if (res_valid) check("tok_ready_low_in_drain", tok_ready, 0);
            if (prev_rv && prev_rr && !prev_last && !prev_abort && !abort)
                check("tok_ready_after_res", tok_ready, 1);
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_result", $sformatf("tok_idx=%0d with nothing expected", tok_idx));
                end else begin
                    mon_r = exp_q.pop_front();
                    check("res_tok_idx", tok_idx, mon_r.idx);
                    check("res_h_sel", h_sel, mon_r.hsel);
                    check("res_last", res_last, mon_r.last);
                    $display("result tok_idx=%0d h_sel=%0b last=%0b", tok_idx, h_sel, res_last);
                end
            end
            if (run_done) begin
                check("starts_per_run", start_in_run, exp_starts);
                check("results_left_at_done", exp_q.size(), 0);
                if (exp_starts == 0) check("tok_ready_in_empty_run", tok_ready_in_run, 0);
                $display("run_done starts=%0d err_timeout=%0b err_spurious=%0b",
                         start_in_run, err_timeout, err_spurious);
                start_in_run     = 0;
                tok_ready_in_run = 0;
            end
            prev_accept = tok_valid && tok_ready;
            prev_done   = core_done;
            prev_rv     = res_valid;
            prev_rr     = res_ready;
            prev_last   = res_last;
            prev_abort  = abort;
            prev_idx    = tok_idx;
        end
    end

    task automatic plan_normal(input int n);
        res_t r;
        for (int i = 0; i < n; i++) begin
            r.idx  = SEQ_W'(i);
            r.hsel = (i != 0);
            r.last = (i == n - 1);
            exp_q.push_back(r);
        end
        exp_starts = n;
    endtask

    task automatic go(input int n);
        @(posedge clk);
        #1;
        cfg_seq_len = SEQ_W'(n);
        cfg_go      = 1'b1;
        @(posedge clk);
        #1;
        cfg_go = 1'b0;
    endtask

    task automatic wait_run_done(input string name, input int budget, output int cycles);
        cycles = 0;
        while (!run_done && cycles < budget) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        if (!run_done) fail_now(name, $sformatf("run_done not seen within %0d cycles", budget));
        @(posedge clk);
        #1;
        check({name, "_busy_after"}, busy, 0);
    endtask

    task automatic wait_start(input string name, input int budget);
        int n;
        n = 0;
        while (!core_start && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!core_start) fail_now(name, "core_start not seen");
    endtask

    initial begin
        int cyc;
        int k;
        int s;

        rst_n       = 1'b0;
        cfg_seq_len = '0;
        cfg_go      = 1'b0;
        abort       = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tok_ready", tok_ready, 0);
        check("rst_core_start", core_start, 0);
        check("rst_h_sel", h_sel, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_last", res_last, 0);
        check("rst_tok_idx", tok_idx, 0);
        check("rst_busy", busy, 0);
        check("rst_run_done", run_done, 0);
        check("rst_err_timeout", err_timeout, 0);
        check("rst_err_spurious", err_spurious, 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Three tokens, 40-cycle core.
        core_lat = 40;
        plan_normal(3);
        go(3);
        check("busy_after_go", busy, 1);
        wait_run_done("three_tokens", 1000, cyc);

        // Empty run.
        exp_starts = 0;
        go(0);
        check("zero_len_done_within_2", (run_done == 1'b1), 1);
        wait_run_done("zero_len", 5, cyc);

        // Core never completes.
        core_lat   = 0;
        exp_starts = 1;
        go(1);
        wait_start("timeout_start", 50);
        k = 0;
        while (!err_timeout && k < 600) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("timeout_latency", k, TIMEOUT);
        check("timeout_finish", run_done, 1);
        wait_run_done("timeout", 10, cyc);
        check("err_timeout_sticky", err_timeout, 1);

        // Completion in the expiry cycle and one cycle before it.
        core_lat = TIMEOUT - 1;
        plan_normal(1);
        go(1);
        check("err_timeout_cleared", err_timeout, 0);
        wait_run_done("done_at_expiry", 700, cyc);
        check("done_at_expiry_no_err", err_timeout, 0);
        core_lat = TIMEOUT - 2;
        plan_normal(1);
        go(1);
        wait_run_done("done_before_expiry", 700, cyc);
        check("done_before_expiry_no_err", err_timeout, 0);

        // Downstream stall on token 0.
        core_lat  = 8;
        ready_pct = 0;
        plan_normal(2);
        go(2);
        k = 0;
        while (!res_valid && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!res_valid) fail_now("stall_res_valid", "res_valid not seen");
        repeat (10) @(posedge clk);
        #1;
        check("stall_res_valid_still", res_valid, 1);
        check("stall_no_second_start", start_in_run, 1);
        ready_pct = 100;
        wait_run_done("stall", 200, cyc);

        // Abort five cycles into token 1.
        core_lat = 20;
        begin
            res_t r;
            r.idx  = '0;
            r.hsel = 1'b0;
            r.last = 1'b0;
            exp_q.push_back(r);
        end
        exp_starts = 2;
        go(3);
        s = 0;
        k = 0;
        while (s < 2 && k < 200) begin
            if (core_start) s++;
            if (s < 2) begin
                @(posedge clk);
                #1;
                k++;
            end
        end
        if (s < 2) fail_now("abort_second_start", "second core_start not seen");
        repeat (5) @(posedge clk);
        #1;
        abort = 1'b1;
        k = 5;
        while (!run_done && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("abort_done_latency", k, 21);
        abort = 1'b0;
        wait_run_done("abort", 5, cyc);
        check("abort_no_timeout", err_timeout, 0);

        // cfg_go mid-run and a stray core_done while fetching.
        core_lat  = 6;
        valid_pct = 0;
        plan_normal(3);
        go(3);
        check("fetch_tok_ready", tok_ready, 1);
        spur_req    = 1'b1;
        cfg_seq_len = SEQ_W'(7);
        cfg_go      = 1'b1;
        @(posedge clk);
        #1;
        cfg_go = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        valid_pct = 100;
        wait_run_done("mid_run_go", 300, cyc);
        check("err_spurious_set", err_spurious, 1);

        // Longest run: tok_idx reaches 2**SEQ_W-2 without wrapping.
        core_lat = 1;
        plan_normal((1 << SEQ_W) - 1);
        go((1 << SEQ_W) - 1);
        check("err_spurious_cleared", err_spurious, 0);
        wait_run_done("max_len", 6000, cyc);

        // Randomized runs.
        for (int i = 0; i < 10; i++) begin
            int n;
            n         = int'($urandom_range(1, 8));
            core_lat  = int'($urandom_range(1, 30));
            valid_pct = int'($urandom_range(30, 100));
            ready_pct = int'($urandom_range(30, 100));
            plan_normal(n);
            go(n);
            wait_run_done("random_run", 3000, cyc);
            check("random_no_err", {err_timeout, err_spurious}, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not finish in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
        $fatal(1, "global timeout");
    end

endmodule
